// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 timing from a 50 MHz clock plus a two-stage
// read-out of the 160x120 frame buffer with 4x4 pixel replication.
module vga_scanout #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int FB_WIDTH    = 160,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [2:0]            rd_data,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_BLANK_N,
    output logic                  VGA_SYNC_N,
    output logic                  VGA_CLK,
    output logic                  vblank,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS   = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_VIS1 = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] V_SS   = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam logic [ADDR_WIDTH-1:0] FB_W = ADDR_WIDTH'(FB_WIDTH);

    logic                  pix_en_q, pix_en_d;
    logic [HW-1:0]         h_q, h_d;
    logic [VW-1:0]         v_q, v_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  vis1_q, vis1_d;
    logic                  hs1_q, hs1_d;
    logic                  vs1_q, vs1_d;
    logic [7:0]            r_q, r_d;
    logic [7:0]            g_q, g_d;
    logic [7:0]            b_q, b_d;
    logic                  hs_q, hs_d;
    logic                  vs_q, vs_d;
    logic                  blank_n_q, blank_n_d;
    logic                  vclk_q, vclk_d;
    logic                  vblank_q, vblank_d;
    logic                  fs_q, fs_d;

    logic                  h_wrap, v_wrap;
    logic                  visible, hs_n, vs_n;
    logic [ADDR_WIDTH-1:0] row, col, lin_addr;

    // Pixel enable toggle and the raster counters
    always_comb begin
        pix_en_d = ~pix_en_q;
        h_wrap   = (h_q == H_LAST);
        v_wrap   = (v_q == V_LAST);
        h_d      = h_q;
        v_d      = v_q;
        if (pix_en_q) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
    end

    // Stage-0 decode of visibility and sync windows
    always_comb begin
        visible = (h_q < H_VIS) && (v_q < V_VIS);
        hs_n    = !((h_q >= H_SS) && (h_q <= H_SE));
        vs_n    = !((v_q >= V_SS) && (v_q <= V_SE));
    end

    // Frame buffer address: row*FB_WIDTH built from shifted partial sums
    always_comb begin
        row      = ADDR_WIDTH'(v_q >> SCALE_SHIFT);
        col      = ADDR_WIDTH'(h_q >> SCALE_SHIFT);
        lin_addr = col;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (FB_W[i]) begin
                lin_addr = lin_addr + (row << i);
            end
        end
    end

    // Pipeline stages 1 and 2, status flags and DAC clock
    always_comb begin
        rd_addr_d = rd_addr_q;
        vis1_d    = vis1_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        vclk_d    = ~pix_en_q;
        vblank_d  = (v_d >= V_VIS);
        fs_d      = pix_en_q && h_wrap && (v_q == V_VIS1);
        if (pix_en_q) begin
            vis1_d = visible;
            hs1_d  = hs_n;
            vs1_d  = vs_n;
            if (visible) begin
                rd_addr_d = lin_addr;
            end
            r_d       = vis1_q ? {8{rd_data[2]}} : 8'h00;
            g_d       = vis1_q ? {8{rd_data[1]}} : 8'h00;
            b_d       = vis1_q ? {8{rd_data[0]}} : 8'h00;
            hs_d      = hs1_q;
            vs_d      = vs1_q;
            blank_n_d = vis1_q;
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_en_q  <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            rd_addr_q <= '0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            vclk_q    <= 1'b0;
            vblank_q  <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            pix_en_q  <= pix_en_d;
            h_q       <= h_d;
            v_q       <= v_d;
            rd_addr_q <= rd_addr_d;
            vis1_q    <= vis1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            vclk_q    <= vclk_d;
            vblank_q  <= vblank_d;
            fs_q      <= fs_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_CLK     = vclk_q;
    assign vblank      = vblank_q;
    assign frame_start = fs_q;

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read side of the 160x120 frame buffer that the square-drawing path writes into.
- Generates 640x480@60 VGA timing from the 50 MHz clock using a 25 MHz pixel enable.
- Scans the frame buffer with 4x4 pixel replication through a synchronous-read port.
- Drives the DAC: R/G/B, HS, VS, BLANK_N, SYNC_N, VGA_CLK.
- Exposes vblank status and a frame_start pulse so drawing logic can schedule updates.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- FB_WIDTH, 160, frame buffer columns
- SCALE_SHIFT, 2, log2 of the pixel replication factor
- ADDR_WIDTH, 15, frame buffer address width

Ports:
- clock  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  out  ADDR_WIDTH  frame buffer read address
- rd_data  in  3  colour returned one clock after rd_addr; bit 2 = R, bit 1 = G, bit 0 = B
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  high during visible pixels
- VGA_SYNC_N  out  1  constant 1
- VGA_CLK  out  1  25 MHz pixel clock to the DAC
- vblank  out  1  high while v_cnt >= V_VISIBLE
- frame_start  out  1  one-clock pulse at entry to vertical blanking

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-line or mid-frame):
  - pix_en=0, h_cnt=0, v_cnt=0, rd_addr=0
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0
  - VGA_CLK=0, vblank=0, frame_start=0, all pipeline registers cleared
- Pixel enable:
  - pix_en toggles every clock and is first high on the first clock after reset deasserts.
  - All counter and pipeline registers advance only on clocks where pix_en=1.
  - VGA_CLK = registered ~pix_en, so its rising edge falls mid-pixel.
- Counters:
  - H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP = 800.
  - V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP = 525.
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - On each h wrap, v_cnt increments, wrapping 0..V_TOTAL-1.
- Stage-0 decode, combinational from the counters:
  - visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hs_n = !(h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]), i.e. pixels 656..751
  - vs_n = !(v_cnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]), i.e. lines 490..491
- Stage 1, registered on pix_en:
  - When visible: rd_addr = (v_cnt>>SCALE_SHIFT)*FB_WIDTH + (h_cnt>>SCALE_SHIFT), using shift-add (row<<7 + row<<5) and truncated to ADDR_WIDTH.
  - When not visible: rd_addr holds its last value.
  - visible, hs_n and vs_n are delayed by one stage alongside rd_addr.
  - Address range is 0..19199 and never exceeds it.
- Stage 2, registered on the next pix_en, two clocks later, by which time rd_data is valid:
  - Each colour channel = {8{rd_data bit}} if the stage-1 visible flag is set, else 8'h00.
  - VGA_HS, VGA_VS and VGA_BLANK_N take the stage-1 values.
  - Total latency from counter position to DAC outputs is exactly 2 pixel periods (4 clocks), identical for sync and colour.
- vblank and frame_start:
  - vblank is registered from v_cnt >= V_VISIBLE.
  - frame_start is high for one clock, on the clock after the pix_en edge where v_cnt changes from V_VISIBLE-1 to V_VISIBLE. It pulses exactly once per frame.
- Ignored inputs: rd_data is ignored outside visible pixels; X or garbage there must not reach the RGB outputs.
- Boundary cases:
  - h_cnt=799 with v_cnt=524: both counters wrap to 0 on the same enable.
  - Frame period = 800*525*2 = 840000 clocks.

Test Plan:
- Reset: hold reset for 5 clocks, then release -> during reset HS=VS=1, BLANK_N=0, RGB=0, rd_addr=0; first pix_en is high 1 clock after release; VGA_CLK period = 2 clocks.
- Line timing: run 2 lines -> HS low for exactly 192 clocks per line; HS period 1600 clocks; BLANK_N high for 1280 clocks per visible line.
- Frame timing: run 2 full frames -> VS low for 3200 clocks; VS period 840000 clocks; frame_start pulses once per frame; vblank high for 45 lines (72000 clocks).
- Addressing: memory model returns addr[2:0] -> rd_addr=321 for h=4..7, v=8..11; rd_addr=19199 at h=639, v=479; rd_addr is never >19199 and holds during blanking.
- Alignment: model drives rd_data=3'b101 for addr 0 only -> VGA_R=FF, G=00, B=FF on the first 4 pixels of lines 0..3, aligned with BLANK_N rising edge; model drives X during blanking -> RGB stays 00.
- Mid-frame reset: assert reset at h=300, v=200 -> outputs reach reset values in the same cycle; after release the scan restarts at (0,0) with the next VS 490 lines later.
